dl_bus_sequencer: RTL

- Sequences the internal/external data bus mux for every memory cycle.
- Arbitrates between two requesters: CPU core (port 0) and DMA engine (port 1).
- Drives the mux select lines, external output-enable and strobe lines, and captures read data from DL.
- Sits between the decoder/DMA request logic and the data-mux/pad ring.

---
 rtl/dl_bus_sequencer_if.sv | 46 ++++
 rtl/dl_bus_sequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/dl_bus_sequencer_if.sv
// Bus bundle between the request logic / pad ring and dl_bus_sequencer.
// Build option: DL_BUS_WAIT_STATE_EN adds the nWAIT input.
interface dl_bus_sequencer_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              Test1;
    logic              cpu_req;
    logic              cpu_we;
    logic              cpu_src;
    logic [ADDR_W-1:0] cpu_addr;
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [7:0]        DL;
`ifdef DL_BUS_WAIT_STATE_EN
    logic              nWAIT;
`endif
    logic [ADDR_W-1:0] A;
    logic              nRD;
    logic              nWR;
    logic              ExtOE;
    logic              Res_to_DL;
    logic              DataOut;
    logic              cpu_ack;
    logic              dma_ack;
    logic              owner;
    logic [7:0]        rdata;

    // Sequencer side.
    modport slave (
`ifdef DL_BUS_WAIT_STATE_EN
        input  nWAIT,
`endif
        input  Test1, cpu_req, cpu_we, cpu_src, cpu_addr, dma_req, dma_we, dma_addr, DL,
        output A, nRD, nWR, ExtOE, Res_to_DL, DataOut, cpu_ack, dma_ack, owner, rdata
    );

    // Requester / pad-ring side.
    modport master (
`ifdef DL_BUS_WAIT_STATE_EN
        output nWAIT,
`endif
        output Test1, cpu_req, cpu_we, cpu_src, cpu_addr, dma_req, dma_we, dma_addr, DL,
        input  A, nRD, nWR, ExtOE, Res_to_DL, DataOut, cpu_ack, dma_ack, owner, rdata
    );
endinterface

// File: rtl/dl_bus_sequencer.sv
// Memory-cycle sequencer for the internal/external data bus mux, CPU vs DMA arbitration.
// Build option: DL_BUS_WAIT_STATE_EN stretches STROBE while nWAIT is low.
module dl_bus_sequencer #(
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = {ADDR_W{1'b1}}
) (
    input logic               CLK,
    input logic               nRESET,
    dl_bus_sequencer_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StAddr, StStrobe, StSample, StDone} state_e;

    state_e            r_state;
    logic              r_owner;
    logic              r_we;
    logic              r_src;
    logic [ADDR_W-1:0] r_a;
    logic              r_nrd;
    logic              r_nwr;
    logic              r_ext_oe;
    logic              r_res_to_dl;
    logic              r_data_out;
    logic              r_cpu_ack;
    logic              r_dma_ack;
    logic [7:0]        r_rdata;

    logic              w_sel_dma;
    logic              w_grant;
    logic              w_sel_we;
    logic              w_sel_src;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_strobe_hold;

    // In DONE the requester just acked is stale, so only the other port may chain.
    assign w_sel_dma  = (r_state == StDone) ? ~r_owner : bus.dma_req;
    assign w_grant    = ~bus.Test1 & ((r_state == StDone) ? (r_owner ? bus.cpu_req : bus.dma_req)
                                                          : (bus.cpu_req | bus.dma_req));
    assign w_sel_we   = w_sel_dma ? bus.dma_we : bus.cpu_we;
    assign w_sel_src  = w_sel_dma ? 1'b0 : bus.cpu_src;
    assign w_sel_addr = w_sel_dma ? bus.dma_addr : bus.cpu_addr;

`ifdef DL_BUS_WAIT_STATE_EN
    assign w_strobe_hold = ~bus.nWAIT;
`else
    assign w_strobe_hold = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state     <= StIdle;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_src       <= 1'b0;
            r_a         <= IDLE_ADDR;
            r_nrd       <= 1'b1;
            r_nwr       <= 1'b1;
            r_ext_oe    <= 1'b0;
            r_res_to_dl <= 1'b0;
            r_data_out  <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_dma_ack   <= 1'b0;
            r_rdata     <= 8'h00;
        end else begin
            r_cpu_ack <= 1'b0;
            r_dma_ack <= 1'b0;
            case (r_state)
                StIdle, StDone: begin
                    if (w_grant) begin
                        r_state <= StAddr;
                        r_owner <= w_sel_dma;
                        r_we    <= w_sel_we;
                        r_src   <= w_sel_src;
                        r_a     <= w_sel_addr;
                    end else begin
                        r_state <= StIdle;
                        r_a     <= IDLE_ADDR;
                    end
                end
                StAddr: begin
                    r_state <= StStrobe;
                    if (r_we) begin
                        r_nwr       <= 1'b0;
                        r_ext_oe    <= ~bus.Test1;
                        r_res_to_dl <= ~r_src;
                        r_data_out  <= r_src;
                    end else begin
                        r_nrd <= 1'b0;
                    end
                end
                StStrobe: begin
                    if (!w_strobe_hold) begin
                        r_state <= StSample;
                    end
                    // Test1 kills the external drive at once; the cycle itself still completes.
                    r_ext_oe <= r_ext_oe & ~bus.Test1;
                end
                StSample: begin
                    r_state     <= StDone;
                    r_nrd       <= 1'b1;
                    r_nwr       <= 1'b1;
                    r_ext_oe    <= 1'b0;
                    r_res_to_dl <= 1'b0;
                    r_data_out  <= 1'b0;
                    if (!r_we) begin
                        r_rdata <= bus.DL;
                    end
                    if (r_owner) begin
                        r_dma_ack <= 1'b1;
                    end else begin
                        r_cpu_ack <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_a     <= IDLE_ADDR;
                end
            endcase
        end
    end

    assign bus.A         = r_a;
    assign bus.nRD       = r_nrd;
    assign bus.nWR       = r_nwr;
    assign bus.ExtOE     = r_ext_oe;
    assign bus.Res_to_DL = r_res_to_dl;
    assign bus.DataOut   = r_data_out;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.dma_ack   = r_dma_ack;
    assign bus.owner     = r_owner;
    assign bus.rdata     = r_rdata;
endmodule
